// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// Operand a comes from Y, b from the bus; results feed the ZHI/ZLO registers.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    count;
    logic             op_lat;
    logic             quo_neg;
    logic             rem_neg;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH:0]   m;

    logic             accept_c;
    logic             dz_c;
    logic             busy_c;
    logic             done_c;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_new;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] rem_res;
    logic [WIDTH-1:0] quo_res;

    // State register
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a zero divisor skips straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (op && (b == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs; busy/done are registered from the current state
    always_comb begin
        accept_c = 1'b0;
        dz_c     = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                accept_c = start;
                dz_c     = start && op && (b == '0);
            end
            RUN:     busy_c = 1'b1;
            FIX:     busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_c;
            done <= done_c;
        end
    end

    // Iteration arithmetic for both operations
    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;

        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m;
            2'b10:   booth_sum = acc - m;
            default: booth_sum = acc;
        endcase

        rem_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
        rem_new   = acc[WIDTH] ? (rem_shift + m) : (rem_shift - m);

        rem_fix = acc[WIDTH] ? (acc[WIDTH-1:0] + m[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_res = rem_neg ? -rem_fix : rem_fix;
        quo_res = quo_neg ? -q : q;
    end

    // Datapath and result registers
    always_ff @(posedge clock) begin
        if (clear) begin
            count       <= '0;
            op_lat      <= 1'b0;
            quo_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            acc         <= '0;
            q           <= '0;
            q_m1        <= 1'b0;
            m           <= '0;
            z_hi        <= '0;
            z_lo        <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept_c) begin
                count       <= '0;
                op_lat      <= op;
                quo_neg     <= a[WIDTH-1] ^ b[WIDTH-1];
                rem_neg     <= a[WIDTH-1];
                acc         <= '0;
                q_m1        <= 1'b0;
                div_by_zero <= dz_c;
                if (op) begin
                    q <= a_mag;
                    m <= {1'b0, b_mag};
                end else begin
                    q <= b;
                    m <= {a[WIDTH-1], a};
                end
                if (dz_c) begin
                    z_hi <= a;
                    z_lo <= '1;
                end
            end

            if (state == RUN) begin
                count <= count + CW'(1);
                if (op_lat) begin
                    acc <= rem_new;
                    q   <= {q[WIDTH-2:0], ~rem_new[WIDTH]};
                end else begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q    <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                end
            end

            if (state == FIX) begin
                if (op_lat) begin
                    z_hi <= rem_res;
                    z_lo <= quo_res;
                end else begin
                    z_hi <= acc[WIDTH-1:0];
                    z_lo <= q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z_hi;
    logic [W-1:0] z_lo;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    localparam logic [W-1:0] MUL_A  [4] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    localparam logic [W-1:0] MUL_B  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0010};
    localparam logic [W-1:0] MUL_HI [4] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000, 32'h0000_0001};
    localparam logic [W-1:0] MUL_LO [4] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h0000_0001, 32'h2345_6780};

    localparam logic [W-1:0] DIV_A  [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7};
    localparam logic [W-1:0] DIV_B  [4] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    localparam logic [W-1:0] DIV_HI [4] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1};
    localparam logic [W-1:0] DIV_LO [4] = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFD};

    mul_div_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .z_hi        (z_hi),
        .z_lo        (z_lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    // Stimulus only: pulse start, scramble inputs afterwards, record the first done
    task automatic run_op(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        lat = -1; busy_cnt = 0; done_cnt = 0; hi = 'x; lo = 'x; dz = 1'bx;
        @(negedge clock);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clock);
        #1;
        start = 1'b0; op = ~o; a = ~av; b = ~bv;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clock);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = n; hi = z_hi; lo = z_lo; dz = div_by_zero;
                end
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({z_hi, z_lo, busy, done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset: z_hi=%h z_lo=%h busy=%b done=%b dz=%b, want all zero",
                     z_hi, z_lo, busy, done, div_by_zero);
        end
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_multiply();
        int lat, bc, dc;
        logic [W-1:0] hi, lo;
        logic dz;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, MUL_A[i], MUL_B[i], lat, bc, dc, hi, lo, dz);
            checks++;
            if (lat !== 34 || bc !== 33 || dc !== 1) begin
                errors++;
                $display("FAIL mul%0d timing: latency=%0d busy=%0d dones=%0d, want 34/33/1", i, lat, bc, dc);
            end
            checks++;
            if (hi !== MUL_HI[i] || lo !== MUL_LO[i]) begin
                errors++;
                $display("FAIL mul%0d result: got %h_%h want %h_%h", i, hi, lo, MUL_HI[i], MUL_LO[i]);
            end
        end
    endtask

    task automatic test_divide();
        int lat, bc, dc;
        logic [W-1:0] hi, lo;
        logic dz;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, DIV_A[i], DIV_B[i], lat, bc, dc, hi, lo, dz);
            checks++;
            if (lat !== 34 || bc !== 33 || dc !== 1) begin
                errors++;
                $display("FAIL div%0d timing: latency=%0d busy=%0d dones=%0d, want 34/33/1", i, lat, bc, dc);
            end
            checks++;
            if (hi !== DIV_HI[i] || lo !== DIV_LO[i] || dz !== 1'b0) begin
                errors++;
                $display("FAIL div%0d result: got rem=%h quo=%h dz=%b want rem=%h quo=%h dz=0",
                         i, hi, lo, dz, DIV_HI[i], DIV_LO[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc, dc;
        logic [W-1:0] hi, lo;
        logic dz;
        run_op(1'b1, 32'h0000_1234, 32'h0, lat, bc, dc, hi, lo, dz);
        checks++;
        if (lat !== 1 || bc !== 0 || dc !== 1) begin
            errors++;
            $display("FAIL dz timing: latency=%0d busy=%0d dones=%0d, want 1/0/1", lat, bc, dc);
        end
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF || dz !== 1'b1) begin
            errors++;
            $display("FAIL dz result: got hi=%h lo=%h dz=%b want 00001234 ffffffff 1", hi, lo, dz);
        end
        checks++;
        if (div_by_zero !== 1'b1 || z_hi !== 32'h0000_1234) begin
            errors++;
            $display("FAIL dz hold: dz=%b z_hi=%h want 1 00001234", div_by_zero, z_hi);
        end
        run_op(1'b1, 32'd100, 32'd7, lat, bc, dc, hi, lo, dz);
        checks++;
        if (dz !== 1'b0 || lo !== 32'd14 || lat !== 34) begin
            errors++;
            $display("FAIL dz cleared: dz=%b quo=%h latency=%0d want 0 0000000e 34", dz, lo, lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        int dc = 0;
        logic [W-1:0] hi = 'x;
        logic [W-1:0] lo = 'x;
        @(negedge clock);
        start = 1'b1; op = 1'b0; a = 32'd7; b = 32'hFFFF_FFFD;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clock);
            #1;
            if (n == 9) begin
                start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd3;
            end else if (n == 10) begin
                start = 1'b0;
            end
            if (done) begin
                dc++;
                if (lat < 0) begin
                    lat = n; hi = z_hi; lo = z_lo;
                end
            end
        end
        checks++;
        if (lat !== 34 || dc !== 1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL ignore_start: latency=%0d dones=%0d result=%h_%h want 34 1 ffffffff_ffffffeb",
                     lat, dc, hi, lo);
        end
    endtask

    task automatic test_clear();
        int dc = 0;
        int bc = 0;
        int lat, bcr, dcr;
        logic [W-1:0] hi, lo;
        logic dz;
        @(negedge clock);
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        clear = 1'b1; start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
        @(posedge clock);
        #1;
        clear = 1'b0; start = 1'b0;
        checks++;
        if ({z_hi, z_lo, busy, done, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL clear state: z_hi=%h z_lo=%h busy=%b done=%b dz=%b, want all zero",
                     z_hi, z_lo, busy, done, div_by_zero);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (done) dc++;
            if (busy) bc++;
        end
        checks++;
        if (dc !== 0 || bc !== 0) begin
            errors++;
            $display("FAIL clear abort: dones=%0d busy cycles=%0d after clear, want 0 0", dc, bc);
        end
        run_op(1'b1, 32'd100, 32'd7, lat, bcr, dcr, hi, lo, dz);
        checks++;
        if (lat !== 34 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL clear rerun: latency=%0d rem=%h quo=%h want 34 2 14", lat, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int dc = 0;
        int consec = 0;
        int bad = 0;
        int first = -1;
        int second = -1;
        logic prev = 1'b0;
        @(negedge clock);
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
        for (int n = 0; n < 80; n++) begin
            @(posedge clock);
            #1;
            if (done) begin
                dc++;
                if (prev) consec++;
                if (z_hi !== 32'd0 || z_lo !== 32'd12) bad++;
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            prev = done;
        end
        start = 1'b0;
        checks++;
        if (dc !== 2 || consec !== 0 || bad !== 0) begin
            errors++;
            $display("FAIL back_to_back: dones=%0d adjacent=%0d wrong results=%0d want 2 0 0", dc, consec, bad);
        end
        checks++;
        if (first !== 34 || second !== 69) begin
            errors++;
            $display("FAIL back_to_back spacing: done at %0d and %0d want 34 and 69", first, second);
        end
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_by_zero();
        test_ignore_start();
        test_clear();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
